// File: rtl/rat_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rat_pkg
//  Description : Shared types and constants for the RAT MCU fetch path.
//  Revision    : 1.0 - initial release
// ============================================================================
package rat_pkg;

    // Program address width of the 1024x18 program ROM
    localparam int PROG_ADDR_W = 10;

    // PC after reset and interrupt service entry address
    localparam logic [PROG_ADDR_W-1:0] RESET_VEC = 10'h000;
    localparam logic [PROG_ADDR_W-1:0] INTR_VEC  = 10'h3FF;

    // Next-PC command issued by decoder/control once per executed instruction
    typedef enum logic [2:0] {
        INC  = 3'd0,
        JMP  = 3'd1,
        CALL = 3'd2,
        RET  = 3'd3,
        RETI = 3'd4,
        HALT = 3'd5,
        SEI  = 3'd6,
        CLI  = 3'd7
    } fetch_cmd_t;

    // Two-phase fetch/execute rhythm
    typedef enum logic {
        FETCH = 1'b0,
        EXEC  = 1'b1
    } fetch_state_t;

endpackage : rat_pkg
`default_nettype wire

// File: rtl/rat_fetch_unit_ret_stack.sv
`default_nettype none
// ============================================================================
//  Module      : ret_stack
//  Description : Register-based LIFO for return addresses. Push when full and
//                pop when empty are silently ignored; the caller flags errors.
//                Top-of-stack is read combinationally.
//  Revision    : 1.0 - initial release
// ============================================================================
module ret_stack #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [WIDTH-1:0]           i_data,
    output logic [WIDTH-1:0]           o_top,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W:0]   r_count;
    logic             w_full;
    logic             w_empty;
    logic             w_do_push;
    logic             w_do_pop;
    logic [PTR_W-1:0] w_wr_idx;
    logic [PTR_W-1:0] w_top_idx;

    assign w_full    = (r_count == (PTR_W+1)'(DEPTH));
    assign w_empty   = (r_count == '0);
    // Push has priority; the fetch unit never requests both in one cycle
    assign w_do_push = i_push & ~w_full;
    assign w_do_pop  = i_pop & ~i_push & ~w_empty;
    // DEPTH is a power of two, so the low pointer bits index storage directly
    assign w_wr_idx  = r_count[PTR_W-1:0];
    assign w_top_idx = r_count[PTR_W-1:0] - PTR_W'(1);

    assign o_top     = r_mem[w_top_idx];
    assign o_count   = r_count;
    assign o_full    = w_full;
    assign o_empty   = w_empty;

    // Occupancy pointer: the only stack state cleared by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_do_push) begin
            r_count <= r_count + (PTR_W+1)'(1);
        end else if (w_do_pop) begin
            r_count <= r_count - (PTR_W+1)'(1);
        end
    end

    // Entry storage, deliberately left uninitialised by reset
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[w_wr_idx] <= i_data;
        end
    end

endmodule : ret_stack
`default_nettype wire

// File: rtl/rat_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : rat_fetch_unit
//  Description : Program counter and fetch sequencer for the RAT MCU. Drives
//                the registered program ROM in a FETCH/EXEC rhythm, applies
//                next-PC commands, owns the return-address stack and vectors
//                interrupts.
//  Revision    : 1.0 - initial release
// ============================================================================
module rat_fetch_unit
    import rat_pkg::*;
#(
    parameter int                ADDR_W      = PROG_ADDR_W,
    parameter int                STACK_DEPTH = 16,
    parameter logic [ADDR_W-1:0] RESET_VEC   = rat_pkg::RESET_VEC,
    parameter logic [ADDR_W-1:0] INTR_VEC    = rat_pkg::INTR_VEC
) (
    input  logic                           PROG_CLK,
    input  logic                           RST_N,
    input  logic [2:0]                     CMD,
    input  logic [ADDR_W-1:0]              TARGET,
    input  logic                           INTR,
    output logic [ADDR_W-1:0]              PROG_ADDR,
    output logic                           IR_VALID,
    output logic                           INT_EN,
    output logic [$clog2(STACK_DEPTH):0]   STACK_CNT,
    output logic                           STACK_ERR
);

    fetch_state_t      r_state;
    logic [ADDR_W-1:0] r_pc;
    logic              r_ir_valid;
    logic              r_int_en;
    logic              r_intr_pending;
    logic              r_stack_err;

    fetch_cmd_t        w_cmd;
    logic              w_exec;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_cmd_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic              w_int_en_nxt;
    logic              w_interruptible;
    logic              w_pend_eff;
    logic              w_take;
    logic              w_push;
    logic              w_pop;
    logic [ADDR_W-1:0] w_push_data;
    logic              w_err_set;

    logic [ADDR_W-1:0]               w_stk_top;
    logic [$clog2(STACK_DEPTH):0]    w_stk_count;
    logic                            w_stk_full;
    logic                            w_stk_empty;

    assign w_cmd      = fetch_cmd_t'(CMD);
    assign w_exec     = (r_state == EXEC);
    assign w_pc_inc   = r_pc + ADDR_W'(1);
    // A request arriving in the closing EXEC cycle is already eligible
    assign w_pend_eff = r_intr_pending | INTR;

    // Next-PC, stack request and interrupt-take decode for the EXEC edge
    always_comb begin
        w_cmd_pc        = w_pc_inc;
        w_int_en_nxt    = r_int_en;
        w_interruptible = 1'b0;
        w_push          = 1'b0;
        w_pop           = 1'b0;
        w_push_data     = w_pc_inc;
        w_err_set       = 1'b0;
        w_take          = 1'b0;
        w_pc_nxt        = r_pc;

        case (w_cmd)
            INC: begin
                w_interruptible = 1'b1;
            end
            JMP: begin
                w_cmd_pc        = TARGET;
                w_interruptible = 1'b1;
            end
            CALL: begin
                w_push      = 1'b1;
                w_push_data = w_pc_inc;
                w_cmd_pc    = TARGET;
            end
            RET, RETI: begin
                // Underflow falls through to PC+1
                if (w_stk_empty) begin
                    w_err_set = 1'b1;
                end else begin
                    w_pop    = 1'b1;
                    w_cmd_pc = w_stk_top;
                end
                if (w_cmd == RETI) begin
                    w_int_en_nxt = 1'b1;
                end
            end
            HALT: begin
                w_cmd_pc        = r_pc;
                w_interruptible = 1'b1;
            end
            SEI: begin
                w_int_en_nxt    = 1'b1;
                w_interruptible = 1'b1;
            end
            CLI: begin
                w_int_en_nxt    = 1'b0;
                w_interruptible = 1'b1;
            end
        endcase

        // Stack-using commands defer the interrupt: one stack op per edge
        w_take = w_interruptible & w_pend_eff & r_int_en;
        if (w_take) begin
            w_push       = 1'b1;
            w_push_data  = w_cmd_pc;
            w_pc_nxt     = INTR_VEC;
            w_int_en_nxt = 1'b0;
        end else begin
            w_pc_nxt     = w_cmd_pc;
        end

        if (w_push && w_stk_full) begin
            w_err_set = 1'b1;
        end

        // Nothing leaves this block outside EXEC
        if (!w_exec) begin
            w_push    = 1'b0;
            w_pop     = 1'b0;
            w_err_set = 1'b0;
            w_take    = 1'b0;
        end
    end

    // Sequencer FSM with PC, interrupt and error state as registered outputs
    always_ff @(posedge PROG_CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state        <= FETCH;
            r_ir_valid     <= 1'b0;
            r_pc           <= RESET_VEC;
            r_int_en       <= 1'b0;
            r_intr_pending <= 1'b0;
            r_stack_err    <= 1'b0;
        end else begin
            case (r_state)
                FETCH: begin
                    r_state    <= EXEC;
                    r_ir_valid <= 1'b1;
                end
                EXEC: begin
                    r_state    <= FETCH;
                    r_ir_valid <= 1'b0;
                    r_pc       <= w_pc_nxt;
                    r_int_en   <= w_int_en_nxt;
                end
            endcase

            if (w_take) begin
                r_intr_pending <= 1'b0;
            end else begin
                r_intr_pending <= w_pend_eff;
            end

            if (w_err_set) begin
                r_stack_err <= 1'b1;
            end
        end
    end

    ret_stack #(
        .WIDTH (ADDR_W),
        .DEPTH (STACK_DEPTH)
    ) u_ret_stack (
        .clk     (PROG_CLK),
        .rst_n   (RST_N),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_push_data),
        .o_top   (w_stk_top),
        .o_count (w_stk_count),
        .o_full  (w_stk_full),
        .o_empty (w_stk_empty)
    );

    assign PROG_ADDR = r_pc;
    assign IR_VALID  = r_ir_valid;
    assign INT_EN    = r_int_en;
    assign STACK_CNT = w_stk_count;
    assign STACK_ERR = r_stack_err;

endmodule : rat_fetch_unit
`default_nettype wire

// File: tb/tb_rat_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rat_fetch_unit
//  Description : Scoreboard bench for rat_fetch_unit with a queue-based
//                architectural model of PC, interrupt flag and return stack.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rat_fetch_unit;
    import rat_pkg::*;

    localparam int C_DEPTH = 16;

    typedef struct {
        logic [9:0] pc;
        logic       ie;
        logic [4:0] cnt;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       RST_N;
    logic [2:0] CMD;
    logic [9:0] TARGET;
    logic       INTR;
    logic [9:0] PROG_ADDR;
    logic       IR_VALID;
    logic       INT_EN;
    logic [4:0] STACK_CNT;
    logic       STACK_ERR;

    int n_cmp  = 0;
    int n_fail = 0;

    // Architectural model state
    logic [9:0] m_pc;
    logic       m_ie;
    logic       m_pend;
    logic       m_err;
    logic [9:0] m_stack [$];

    exp_t sb_q [$];
    logic prev_v = 1'b0;

    rat_fetch_unit u_dut (
        .PROG_CLK  (clk),
        .RST_N     (RST_N),
        .CMD       (CMD),
        .TARGET    (TARGET),
        .INTR      (INTR),
        .PROG_ADDR (PROG_ADDR),
        .IR_VALID  (IR_VALID),
        .INT_EN    (INT_EN),
        .STACK_CNT (STACK_CNT),
        .STACK_ERR (STACK_ERR)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc   = 10'h000;
        m_ie   = 1'b0;
        m_pend = 1'b0;
        m_err  = 1'b0;
        m_stack.delete();
    endtask

    task automatic model_push(input logic [9:0] a);
        if (m_stack.size() == C_DEPTH) m_err = 1'b1;
        else m_stack.push_back(a);
    endtask

    // One executed instruction, straight from the architectural rules
    task automatic model_step(input logic [2:0] c, input logic [9:0] t, input logic irq);
        logic [9:0] seq;
        logic [9:0] npc;
        logic       ie_before;
        logic       pend;
        bit         can_take;
        seq       = m_pc + 10'd1;
        npc       = seq;
        ie_before = m_ie;
        pend      = m_pend | irq;
        can_take  = (c == INC) || (c == JMP) || (c == HALT) || (c == SEI) || (c == CLI);
        if (c == JMP || c == CALL) npc = t;
        if (c == HALT) npc = m_pc;
        if (c == CALL) model_push(seq);
        if (c == RET || c == RETI) begin
            if (m_stack.size() == 0) m_err = 1'b1;
            else npc = m_stack.pop_back();
        end
        if (c == RETI || c == SEI) m_ie = 1'b1;
        if (c == CLI) m_ie = 1'b0;
        if (can_take && pend && ie_before) begin
            model_push(npc);
            npc    = 10'h3FF;
            m_ie   = 1'b0;
            m_pend = 1'b0;
        end else begin
            m_pend = pend;
        end
        m_pc = npc;
    endtask

    // Apply one command in the next EXEC cycle and queue its expected result
    task automatic do_instr(input logic [2:0] c, input logic [9:0] t, input logic irq);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (!IR_VALID && n < 4) begin
            @(negedge clk);
            n++;
        end
        if (!IR_VALID) check("exec_timeout", 32'(IR_VALID), 32'd1);
        CMD    = c;
        TARGET = t;
        INTR   = irq;
        model_step(c, t, irq);
        e.pc  = m_pc;
        e.ie  = m_ie;
        e.cnt = 5'(m_stack.size());
        e.err = m_err;
        sb_q.push_back(e);
        @(negedge clk);
        INTR = 1'b0;
        CMD  = INC;
    endtask

    task automatic reset_dut();
        #2;
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        RST_N = 1'b0;
        #1;
        check("rst_pc",  32'(PROG_ADDR), 32'h000);
        check("rst_cnt", 32'(STACK_CNT), 32'd0);
        check("rst_err", 32'(STACK_ERR), 32'd0);
        @(negedge clk);
        RST_N = 1'b1;
        model_reset();
    endtask

    // Monitor: each EXEC->FETCH transition presents one retired instruction
    always @(negedge clk) begin
        exp_t e;
        if (RST_N && prev_v && !IR_VALID && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("pc",        32'(PROG_ADDR), 32'(e.pc));
            check("int_en",    32'(INT_EN),    32'(e.ie));
            check("stack_cnt", 32'(STACK_CNT), 32'(e.cnt));
            check("stack_err", 32'(STACK_ERR), 32'(e.err));
        end
        prev_v = IR_VALID;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0] exp_addr [5];
        logic       exp_v    [5];
        logic [2:0] rc;
        int         r;

        RST_N  = 1'b0;
        CMD    = INC;
        TARGET = '0;
        INTR   = 1'b0;
        model_reset();
        #1;
        check("rst_pc",       32'(PROG_ADDR), 32'h000);
        check("rst_ir_valid", 32'(IR_VALID),  32'd0);
        check("rst_int_en",   32'(INT_EN),    32'd0);
        check("rst_cnt",      32'(STACK_CNT), 32'd0);
        check("rst_err",      32'(STACK_ERR), 32'd0);
        @(negedge clk);
        @(negedge clk);
        RST_N = 1'b1;

        // Reset release with INC held
        exp_addr = '{10'h000, 10'h000, 10'h001, 10'h001, 10'h002};
        exp_v    = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            check("seq_addr",     32'(PROG_ADDR), 32'(exp_addr[i]));
            check("seq_ir_valid", 32'(IR_VALID),  32'(exp_v[i]));
        end
        model_step(INC, '0, 1'b0);
        model_step(INC, '0, 1'b0);

        // Jump to the top of memory and wrap
        do_instr(JMP, 10'h3FF, 1'b0);
        do_instr(INC, 10'h000, 1'b0);

        // Call and return
        do_instr(JMP, 10'h010, 1'b0);
        do_instr(CALL, 10'h120, 1'b0);
        do_instr(RET, 10'h000, 1'b0);

        // Overflow then underflow
        reset_dut();
        for (int i = 0; i < 17; i++) do_instr(CALL, 10'h050, 1'b0);
        for (int i = 0; i < 17; i++) do_instr(RET, 10'h000, 1'b0);

        // Interrupt during JMP, then RETI
        reset_dut();
        do_instr(SEI, 10'h000, 1'b0);
        do_instr(JMP, 10'h200, 1'b1);
        do_instr(RETI, 10'h000, 1'b0);

        // Interrupt deferred across a CALL
        do_instr(CALL, 10'h0A0, 1'b1);
        do_instr(INC, 10'h000, 1'b0);
        do_instr(RETI, 10'h000, 1'b0);
        do_instr(RET, 10'h000, 1'b0);

        // CLI keeps the request pending; SEI lets it through later
        do_instr(CLI, 10'h000, 1'b1);
        do_instr(INC, 10'h000, 1'b0);
        do_instr(SEI, 10'h000, 1'b0);
        do_instr(HALT, 10'h000, 1'b0);

        // Asynchronous reset in the middle of EXEC
        do_instr(CALL, 10'h155, 1'b0);
        @(negedge clk);
        CMD    = CALL;
        TARGET = 10'h2AA;
        #2;
        RST_N = 1'b0;
        #1;
        check("mid_rst_pc",       32'(PROG_ADDR), 32'h000);
        check("mid_rst_cnt",      32'(STACK_CNT), 32'd0);
        check("mid_rst_int_en",   32'(INT_EN),    32'd0);
        check("mid_rst_ir_valid", 32'(IR_VALID),  32'd0);
        @(negedge clk);
        CMD   = INC;
        RST_N = 1'b1;
        model_reset();
        do_instr(INC, 10'h000, 1'b0);

        // Randomized stream
        for (int i = 0; i < 300; i++) begin
            r  = $urandom_range(0, 15);
            rc = (r < 8) ? 3'(r) : ((r < 11) ? CALL : ((r < 13) ? RET : INC));
            do_instr(rc, 10'($urandom), ($urandom_range(0, 7) == 0));
            if (i == 150) reset_dut();
        end

        #2;
        check("sb_final_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_rat_fetch_unit
`default_nettype wire

// File: doc/rat_fetch_unit.md
Name: rat_fetch_unit

Overview:
Program-counter and fetch sequencer for the RAT MCU. It sits directly upstream of the 1024x18 program ROM and drives PROG_ADDR. It sequences the ROM's one-cycle registered read into a two-phase fetch/execute rhythm. It holds a hardware return-address stack and handles interrupt vectoring. Decoder/control issues one next-PC command per executed instruction.

Parameters:
ADDR_W, 10, program address width (1024 words)
STACK_DEPTH, 16, return-address stack entries (power of 2)
RESET_VEC, 10'h000, PC after reset
INTR_VEC, 10'h3FF, interrupt service entry address

Ports:
PROG_CLK  in  1  system clock, all state on rising edge
RST_N  in  1  asynchronous active-low reset
CMD  in  3  next-PC command, sampled only in EXEC (encoding in package)
TARGET  in  ADDR_W  branch/call target (decoder supplies IR[12:3])
INTR  in  1  interrupt request, level, sampled every cycle
PROG_ADDR  out  ADDR_W  address to program ROM (= PC register)
IR_VALID  out  1  high in EXEC: ROM output PROG_IR is valid this cycle
INT_EN  out  1  interrupt enable flag
STACK_CNT  out  $clog2(STACK_DEPTH)+1  occupied stack entries
STACK_ERR  out  1  sticky overflow/underflow flag

Behaviour:
- Reset (async, RST_N=0) sets:
  - PC=RESET_VEC, state=FETCH, IR_VALID=0.
  - INT_EN=0, intr_pending=0, STACK_CNT=0, STACK_ERR=0.
  - Reset mid-EXEC discards the in-flight command.
- FSM states: FETCH -> EXEC -> FETCH, one cycle each. There is no other state.
  - FETCH: PROG_ADDR=PC and the ROM registers the word. IR_VALID=0. CMD is ignored.
  - EXEC: IR_VALID=1. CMD is applied at the closing edge, and PC updates at that edge.
  - The new PROG_ADDR is visible in the following FETCH.
  - Throughput: one instruction per 2 cycles.
- CMD encoding and resulting next_pc:
  - INC=0: next_pc = PC+1.
  - JMP=1: next_pc = TARGET.
  - CALL=2: push PC+1, then next_pc = TARGET.
  - RET=3: pop into next_pc.
  - RETI=4: pop into next_pc, and INT_EN<=1.
  - HALT=5: next_pc = PC (re-fetch the same word).
  - SEI=6: INT_EN<=1, next_pc = PC+1.
  - CLI=7: INT_EN<=0, next_pc = PC+1.
- PC arithmetic is modulo 2^ADDR_W: 0x3FF+1 = 0x000. Pushed addresses wrap the same way.
- Interrupt handling:
  - intr_pending is set on any cycle with INTR=1. It is cleared only when the interrupt is taken. CLI does not clear it.
  - The interrupt is taken at the end of EXEC when intr_pending=1, INT_EN=1 (the pre-edge value) and CMD is one of INC/JMP/HALT/SEI/CLI.
  - On take: push next_pc, PC<=INTR_VEC, INT_EN<=0, intr_pending<=0. This overrides the SEI/CLI effect on INT_EN.
  - During CALL/RET/RETI the interrupt is deferred: it stays pending and is evaluated at the next EXEC. This guarantees at most one stack operation per edge.
- Stack overflow: a push when STACK_CNT=STACK_DEPTH is dropped. Stack contents are unchanged, STACK_ERR<=1, and PC still moves to its target.
- Stack underflow: a pop when STACK_CNT=0 gives next_pc = PC+1, STACK_ERR<=1, and STACK_CNT stays 0.
- STACK_ERR is cleared only by reset.
- Stack storage is plain registers and is not cleared by reset (only the pointer is). Stack reads are combinational from the top-of-stack.

Decomposition:
- Package rat_pkg holds:
  - typedef enum logic[2:0] fetch_cmd_t (INC, JMP, CALL, RET, RETI, HALT, SEI, CLI).
  - typedef enum logic fetch_state_t {FETCH, EXEC}.
  - Constants PROG_ADDR_W=10, RESET_VEC, INTR_VEC.
- Sub-module ret_stack: LIFO with push/pop/data_in/top/count/full/empty, parameterised by width and depth.
  - It asserts nothing on error. rat_fetch_unit generates STACK_ERR.

Test Plan:
1. Reset release with CMD=INC held:
   - PROG_ADDR sequence 000,000,001,001,002.
   - IR_VALID toggles 0,1,0,1 starting in FETCH.
2. JMP TARGET=3FF, then INC:
   - PROG_ADDR goes to 3FF, then wraps to 000.
   - STACK_ERR stays 0.
3. At PC=010, CALL TARGET=120; then RET:
   - After the CALL: PROG_ADDR=120, STACK_CNT=1.
   - After the RET: PROG_ADDR=011, STACK_CNT=0.
4. 17 consecutive CALLs to 050, then 17 RETs:
   - STACK_CNT saturates at 16 with STACK_ERR=1.
   - 16 RETs return correct addresses; the 17th yields PC+1 with STACK_CNT=0.
5. SEI, then INTR pulse during an EXEC with CMD=JMP 200:
   - PC=3FF, INT_EN=0, stack top=200.
   - RETI returns to 200 with INT_EN=1.
6. Two deferral/reset cases:
   - INTR with INT_EN=1 during CALL: the call is taken first; the interrupt is taken at the next EXEC.
   - RST_N low mid-EXEC: PROG_ADDR=000, STACK_CNT=0, INT_EN=0 immediately (asynchronous).
